// File: rtl/rdback_serializer.sv
// Drains the read-back FIFO one entry at a time and streams each entry to the host
// as NBEATS HOST_WIDTH-bit beats, least significant slice first.
module rdback_serializer #(
    parameter int DQ_WIDTH   = 64,
    parameter int HOST_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdback_fifo_empty,
    output logic                  rdback_fifo_rden,
    input  logic [4*DQ_WIDTH-1:0] rdback_data,
    input  logic                  burst_start,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    output logic [HOST_WIDTH-1:0] host_data,
    output logic                  host_valid,
    input  logic                  host_ready,
    output logic                  host_last,
    output logic                  busy,
    output logic [LEN_WIDTH-1:0]  entries_sent
);
    localparam int ENTRY_WIDTH = 4 * DQ_WIDTH;
    localparam int NBEATS      = ENTRY_WIDTH / HOST_WIDTH;
    localparam int BEAT_WIDTH  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [BEAT_WIDTH-1:0] LAST_BEAT = BEAT_WIDTH'(NBEATS - 1);

    typedef enum logic [1:0] {IDLE, FETCH, LOAD, SEND} state_t;

    state_t                 state_reg, state_next;
    logic [ENTRY_WIDTH-1:0] shift_reg, shift_next;
    logic [BEAT_WIDTH-1:0]  beat_reg, beat_next;
    logic [LEN_WIDTH-1:0]   remaining_reg, remaining_next;
    logic [LEN_WIDTH-1:0]   sent_reg, sent_next;
    logic                   busy_reg, busy_next;
    logic                   beat_fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            shift_reg     <= '0;
            beat_reg      <= '0;
            remaining_reg <= '0;
            sent_reg      <= '0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            shift_reg     <= shift_next;
            beat_reg      <= beat_next;
            remaining_reg <= remaining_next;
            sent_reg      <= sent_next;
            busy_reg      <= busy_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        shift_next     = shift_reg;
        beat_next      = beat_reg;
        remaining_next = remaining_reg;
        sent_next      = sent_reg;
        busy_next      = busy_reg;
        beat_fire      = (state_reg == SEND) && host_ready;

        case (state_reg)
            IDLE: begin
                // Zero-length requests never start a transfer.
                if (burst_start && (burst_len != '0)) begin
                    remaining_next = burst_len;
                    sent_next      = '0;
                    busy_next      = 1'b1;
                    state_next     = FETCH;
                end
            end
            FETCH: begin
                if (!rdback_fifo_empty) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                // Standard-mode FIFO: data popped in FETCH is presented now.
                shift_next = rdback_data;
                beat_next  = '0;
                state_next = SEND;
            end
            SEND: begin
                if (beat_fire) begin
                    shift_next = shift_reg >> HOST_WIDTH;
                    beat_next  = beat_reg + 1'b1;
                    if (beat_reg == LAST_BEAT) begin
                        sent_next      = sent_reg + 1'b1;
                        remaining_next = remaining_reg - 1'b1;
                        if (remaining_reg == LEN_WIDTH'(1)) begin
                            busy_next  = 1'b0;
                            state_next = IDLE;
                        end else begin
                            state_next = FETCH;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign rdback_fifo_rden = (state_reg == FETCH) && !rdback_fifo_empty;
    assign host_valid       = (state_reg == SEND);
    assign host_data        = shift_reg[HOST_WIDTH-1:0];
    assign host_last        = (state_reg == SEND) && (beat_reg == LAST_BEAT) &&
                              (remaining_reg == LEN_WIDTH'(1));
    assign busy             = busy_reg;
    assign entries_sent     = sent_reg;

endmodule

// File: tb/tb_rdback_serializer.sv
// Randomized bench for rdback_serializer: a queue-based FIFO model feeds the DUT and
// the expected host stream is the concatenation of each popped entry's 32-bit slices.
`timescale 1ns/1ps
module tb_rdback_serializer;
    localparam int DQ_WIDTH   = 64;
    localparam int HOST_WIDTH = 32;
    localparam int LEN_WIDTH  = 16;
    localparam int EW         = 4 * DQ_WIDTH;
    localparam int NB         = EW / HOST_WIDTH;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  rdback_fifo_empty;
    logic                  rdback_fifo_rden;
    logic [EW-1:0]         rdback_data = '0;
    logic                  burst_start = 1'b0;
    logic [LEN_WIDTH-1:0]  burst_len = '0;
    logic [HOST_WIDTH-1:0] host_data;
    logic                  host_valid;
    logic                  host_ready = 1'b1;
    logic                  host_last;
    logic                  busy;
    logic [LEN_WIDTH-1:0]  entries_sent;

    rdback_serializer #(
        .DQ_WIDTH(DQ_WIDTH), .HOST_WIDTH(HOST_WIDTH), .LEN_WIDTH(LEN_WIDTH)
    ) dut (
        .clk(clk), .rst(rst),
        .rdback_fifo_empty(rdback_fifo_empty), .rdback_fifo_rden(rdback_fifo_rden),
        .rdback_data(rdback_data),
        .burst_start(burst_start), .burst_len(burst_len),
        .host_data(host_data), .host_valid(host_valid), .host_ready(host_ready),
        .host_last(host_last), .busy(busy), .entries_sent(entries_sent)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // FIFO model: standard mode, data appears the cycle after the pop strobe.
    logic [EW-1:0] fifo_mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    logic pop_pending = 1'b0;
    int cyc = 0;
    assign rdback_fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pop_pending) begin
            rdback_data <= fifo_mem[rd_ptr % 256];
            rd_ptr      <= rd_ptr + 1;
        end
    end

    // Observation side: accepted beats, pop strobes and stall stability.
    logic [HOST_WIDTH-1:0] obs_data [$];
    logic                  obs_last [$];
    logic [HOST_WIDTH-1:0] exp_data [$];
    int rden_cnt = 0;
    int rden_bad = 0;
    int hold_bad = 0;
    logic hold_pending = 1'b0;
    logic [HOST_WIDTH-1:0] hold_data = '0;
    logic hold_last = 1'b0;

    always @(negedge clk) begin
        pop_pending = rdback_fifo_rden && !rdback_fifo_empty;
        if (rdback_fifo_rden) begin
            rden_cnt++;
            if (rdback_fifo_empty) rden_bad++;
        end
        if (host_valid && host_ready) begin
            obs_data.push_back(host_data);
            obs_last.push_back(host_last);
        end
        if (hold_pending && (host_valid !== 1'b1 || host_data !== hold_data || host_last !== hold_last))
            hold_bad++;
        hold_pending = host_valid && !host_ready && !rst;
        hold_data    = host_data;
        hold_last    = host_last;
    end

    function automatic logic [EW-1:0] rand_entry();
        logic [EW-1:0] e;
        for (int i = 0; i < EW / 32; i++) e[i*32 +: 32] = $urandom;
        return e;
    endfunction

    task automatic push_entry(input logic [EW-1:0] e);
        fifo_mem[wr_ptr % 256] = e;
        wr_ptr++;
    endtask

    // Reference: an entry contributes NB beats, beat k being bits [k*HW +: HW].
    task automatic model_add(input logic [EW-1:0] e);
        for (int k = 0; k < NB; k++) exp_data.push_back(HOST_WIDTH'(e >> (k * HOST_WIDTH)));
    endtask

    task automatic clear_obs();
        obs_data.delete();
        obs_last.delete();
        exp_data.delete();
        rden_cnt = 0;
        rden_bad = 0;
        hold_bad = 0;
    endtask

    task automatic start_burst(input int len);
        @(posedge clk); #1;
        burst_start = 1'b1;
        burst_len   = LEN_WIDTH'(len);
        @(posedge clk); #1;
        burst_start = 1'b0;
        burst_len   = LEN_WIDTH'($urandom);
    endtask

    // mode 0: ready held high, 1: toggling, 2: random
    task automatic run_until_idle(input int mode, output bit timeout);
        timeout = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (!busy) begin
                timeout = 1'b0;
                break;
            end
            if (mode == 1) host_ready = ~host_ready;
            else if (mode == 2) host_ready = 1'($urandom_range(0, 1));
            else host_ready = 1'b1;
            @(posedge clk); #1;
        end
        host_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({rdback_fifo_rden, host_valid, host_last, busy} !== 4'b0000 ||
            host_data !== '0 || entries_sent !== '0) begin
            errors++;
            $display("FAIL reset_values got rden=%b valid=%b last=%b busy=%b data=%h sent=%0d exp all zero",
                     rdback_fifo_rden, host_valid, host_last, busy, host_data, entries_sent);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [EW-1:0] e;
        clear_obs();
        for (int i = 0; i < NB; i++) e[i*HOST_WIDTH +: HOST_WIDTH] = HOST_WIDTH'(i);
        push_entry(e);
        model_add(e);
        host_ready = 1'b1;
        @(posedge clk); #1;
        burst_start = 1'b1;
        burst_len   = 1;
        @(posedge clk); #1;
        burst_start = 1'b0;
        for (int j = 1; j <= 11; j++) begin
            @(negedge clk);
            checks++;
            if ({rdback_fifo_rden, host_valid, host_last, busy} !==
                {j == 1, (j >= 3) && (j <= 10), j == 10, j <= 10}) begin
                errors++;
                $display("FAIL single_timing T+%0d got rden=%b valid=%b last=%b busy=%b exp %b%b%b%b", j,
                         rdback_fifo_rden, host_valid, host_last, busy,
                         j == 1, (j >= 3) && (j <= 10), j == 10, j <= 10);
            end
        end
        checks++;
        if (obs_data.size() != exp_data.size()) begin
            errors++;
            $display("FAIL single_count got %0d beats exp %0d", obs_data.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size(); i++) begin
            checks++;
            if (i >= obs_data.size() || obs_data[i] !== exp_data[i] || obs_last[i] !== (i == exp_data.size() - 1)) begin
                errors++;
                $display("FAIL single_beat %0d got %h last=%b exp %h last=%b", i,
                         obs_data[i], obs_last[i], exp_data[i], i == exp_data.size() - 1);
            end
        end
        checks++;
        if (entries_sent !== 1 || rden_cnt != 1 || rden_bad != 0) begin
            errors++;
            $display("FAIL single_counts got sent=%0d pops=%0d bad=%0d exp 1 1 0", entries_sent, rden_cnt, rden_bad);
        end
    endtask

    task automatic test_backpressure();
        logic [EW-1:0] e;
        bit to;
        clear_obs();
        for (int n = 0; n < 3; n++) begin
            e = rand_entry();
            push_entry(e);
            model_add(e);
        end
        host_ready = 1'b0;
        start_burst(3);
        run_until_idle(1, to);
        checks++;
        if (to) begin errors++; $display("FAIL bp_timeout busy still %b exp 0", busy); end
        checks++;
        if (obs_data.size() != exp_data.size()) begin
            errors++;
            $display("FAIL bp_count got %0d beats exp %0d", obs_data.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size(); i++) begin
            checks++;
            if (i >= obs_data.size() || obs_data[i] !== exp_data[i] || obs_last[i] !== (i == exp_data.size() - 1)) begin
                errors++;
                $display("FAIL bp_beat %0d got %h last=%b exp %h last=%b", i,
                         obs_data[i], obs_last[i], exp_data[i], i == exp_data.size() - 1);
            end
        end
        checks++;
        if (hold_bad != 0 || rden_cnt != 3 || rden_bad != 0 || entries_sent !== 3) begin
            errors++;
            $display("FAIL bp_counts got hold_bad=%0d pops=%0d bad=%0d sent=%0d exp 0 3 0 3",
                     hold_bad, rden_cnt, rden_bad, entries_sent);
        end
    endtask

    task automatic test_starvation();
        logic [EW-1:0] e1, e2;
        bit to;
        clear_obs();
        e1 = rand_entry();
        e2 = rand_entry();
        push_entry(e1);
        model_add(e1);
        model_add(e2);
        host_ready = 1'b1;
        start_burst(2);
        to = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (obs_data.size() == NB) begin to = 1'b0; break; end
            @(posedge clk); #1;
        end
        checks++;
        if (to) begin errors++; $display("FAIL starve_first got %0d beats exp %0d", obs_data.size(), NB); end
        repeat (50) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || host_valid !== 1'b0 || rden_cnt != 1 || rden_bad != 0 || obs_data.size() != NB) begin
            errors++;
            $display("FAIL starve_wait got busy=%b valid=%b pops=%0d bad=%0d beats=%0d exp 1 0 1 0 %0d",
                     busy, host_valid, rden_cnt, rden_bad, obs_data.size(), NB);
        end
        push_entry(e2);
        run_until_idle(2, to);
        checks++;
        if (to) begin errors++; $display("FAIL starve_timeout busy still %b exp 0", busy); end
        checks++;
        if (obs_data.size() != exp_data.size()) begin
            errors++;
            $display("FAIL starve_count got %0d beats exp %0d", obs_data.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size(); i++) begin
            checks++;
            if (i >= obs_data.size() || obs_data[i] !== exp_data[i] || obs_last[i] !== (i == exp_data.size() - 1)) begin
                errors++;
                $display("FAIL starve_beat %0d got %h last=%b exp %h last=%b", i,
                         obs_data[i], obs_last[i], exp_data[i], i == exp_data.size() - 1);
            end
        end
        checks++;
        if (rden_cnt != 2 || rden_bad != 0 || hold_bad != 0 || entries_sent !== 2) begin
            errors++;
            $display("FAIL starve_counts got pops=%0d bad=%0d hold_bad=%0d sent=%0d exp 2 0 0 2",
                     rden_cnt, rden_bad, hold_bad, entries_sent);
        end
    endtask

    task automatic test_zero_and_ignore();
        logic [EW-1:0] e;
        bit to;
        clear_obs();
        for (int n = 0; n < 2; n++) begin
            e = rand_entry();
            push_entry(e);
            model_add(e);
        end
        start_burst(0);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || rden_cnt != 0 || obs_data.size() != 0) begin
            errors++;
            $display("FAIL zero_len got busy=%b pops=%0d beats=%0d exp 0 0 0", busy, rden_cnt, obs_data.size());
        end
        start_burst(2);
        repeat (6) begin
            host_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        burst_start = 1'b1;
        burst_len   = 5;
        @(posedge clk); #1;
        burst_start = 1'b0;
        run_until_idle(2, to);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (to || busy !== 1'b0) begin errors++; $display("FAIL ignore_idle got busy=%b timeout=%b exp 0 0", busy, to); end
        checks++;
        if (obs_data.size() != exp_data.size()) begin
            errors++;
            $display("FAIL ignore_count got %0d beats exp %0d", obs_data.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size(); i++) begin
            checks++;
            if (i >= obs_data.size() || obs_data[i] !== exp_data[i] || obs_last[i] !== (i == exp_data.size() - 1)) begin
                errors++;
                $display("FAIL ignore_beat %0d got %h last=%b exp %h last=%b", i,
                         obs_data[i], obs_last[i], exp_data[i], i == exp_data.size() - 1);
            end
        end
        checks++;
        if (rden_cnt != 2 || rden_bad != 0 || hold_bad != 0 || entries_sent !== 2) begin
            errors++;
            $display("FAIL ignore_counts got pops=%0d bad=%0d hold_bad=%0d sent=%0d exp 2 0 0 2",
                     rden_cnt, rden_bad, hold_bad, entries_sent);
        end
    endtask

    task automatic test_back_to_back();
        logic [EW-1:0] e;
        bit to;
        int len;
        for (int b = 0; b < 4; b++) begin
            clear_obs();
            len = $urandom_range(1, 4);
            for (int n = 0; n < len; n++) begin
                e = rand_entry();
                push_entry(e);
                model_add(e);
            end
            start_burst(len);
            checks++;
            if (entries_sent !== 0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL b2b_start%0d got sent=%0d busy=%b exp 0 1", b, entries_sent, busy);
            end
            run_until_idle(2, to);
            checks++;
            if (to || obs_data.size() != exp_data.size()) begin
                errors++;
                $display("FAIL b2b_count%0d got %0d beats timeout=%b exp %0d", b, obs_data.size(), to, exp_data.size());
            end
            for (int i = 0; i < exp_data.size(); i++) begin
                checks++;
                if (i >= obs_data.size() || obs_data[i] !== exp_data[i] || obs_last[i] !== (i == exp_data.size() - 1)) begin
                    errors++;
                    $display("FAIL b2b_beat%0d %0d got %h last=%b exp %h last=%b", b, i,
                             obs_data[i], obs_last[i], exp_data[i], i == exp_data.size() - 1);
                end
            end
            checks++;
            if (rden_cnt != len || rden_bad != 0 || hold_bad != 0 || entries_sent !== LEN_WIDTH'(len)) begin
                errors++;
                $display("FAIL b2b_counts%0d got pops=%0d bad=%0d hold_bad=%0d sent=%0d exp %0d 0 0 %0d",
                         b, rden_cnt, rden_bad, hold_bad, entries_sent, len, len);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [EW-1:0] e1, e2;
        bit to;
        clear_obs();
        e1 = rand_entry();
        e2 = rand_entry();
        push_entry(e1);
        push_entry(e2);
        model_add(e1);
        host_ready = 1'b1;
        start_burst(2);
        to = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (obs_data.size() == 3) begin to = 1'b0; break; end
            @(posedge clk); #1;
        end
        rst        = 1'b1;
        host_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (to || {rdback_fifo_rden, host_valid, host_last, busy} !== 4'b0000 ||
            host_data !== '0 || entries_sent !== '0) begin
            errors++;
            $display("FAIL midreset_values got rden=%b valid=%b last=%b busy=%b data=%h sent=%0d timeout=%b exp all zero",
                     rdback_fifo_rden, host_valid, host_last, busy, host_data, entries_sent, to);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= obs_data.size() || obs_data[i] !== exp_data[i] || obs_last[i] !== 1'b0) begin
                errors++;
                $display("FAIL midreset_prefix %0d got %h last=%b exp %h last=0", i, obs_data[i], obs_last[i], exp_data[i]);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        clear_obs();
        model_add(e2);
        host_ready = 1'b1;
        start_burst(1);
        run_until_idle(2, to);
        checks++;
        if (to || obs_data.size() != exp_data.size()) begin
            errors++;
            $display("FAIL midreset_count got %0d beats timeout=%b exp %0d", obs_data.size(), to, exp_data.size());
        end
        for (int i = 0; i < exp_data.size(); i++) begin
            checks++;
            if (i >= obs_data.size() || obs_data[i] !== exp_data[i] || obs_last[i] !== (i == exp_data.size() - 1)) begin
                errors++;
                $display("FAIL midreset_beat %0d got %h last=%b exp %h last=%b", i,
                         obs_data[i], obs_last[i], exp_data[i], i == exp_data.size() - 1);
            end
        end
        checks++;
        if (rden_cnt != 1 || rden_bad != 0 || entries_sent !== 1) begin
            errors++;
            $display("FAIL midreset_counts got pops=%0d bad=%0d sent=%0d exp 1 0 1", rden_cnt, rden_bad, entries_sent);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_starvation();
        test_zero_and_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
